// File: rtl/debug_word_loader.sv
// debug_word_loader
//   Loads the instruction memory of the MIPS debug path from a UART byte stream.
//   Received bytes are packed into NBITS-wide words, in either byte order. Each
//   finished word is written to instruction memory at an address that increments
//   automatically. The load ends when the END_WORD marker arrives; that marker is
//   never written. An inter-byte timeout or a memory overflow raises the sticky
//   error flag.
//
// Ports
//   i_clk, i_reset  clock; asynchronous active-high reset
//   i_start         1-cycle pulse that arms a load (acted on only in IDLE)
//   i_rx_ready      byte-valid level from the UART rx; only its rising edge counts
//   i_rx_data       received byte
//   o_mem_addr      write address, held until the next strobe
//   o_mem_data      write data, held until the next strobe
//   o_mem_write     1-cycle write strobe
//   o_busy          high in RECV and WRITE
//   o_done          1-cycle pulse when the load ends on END_WORD
//   o_error         sticky timeout/overflow flag, cleared by the next accepted start
//   o_word_count    number of words written in the current or last load
//   o_state         IDLE=0 RECV=1 WRITE=2 DONE=3 ERROR=4
module debug_word_loader #(
  parameter int              NBITS        = 32,
  parameter int              DATA_BITS    = 8,
  parameter int              ADDR_BITS    = 8,
  parameter bit              MSB_FIRST    = 1'b1,
  parameter logic [NBITS-1:0] END_WORD    = '1,
  parameter int              BYTE_TIMEOUT = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_rx_ready,
  input  logic [DATA_BITS-1:0] i_rx_data,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [NBITS-1:0]     o_mem_data,
  output logic                 o_mem_write,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [ADDR_BITS:0]   o_word_count,
  output logic [2:0]           o_state
);

  localparam int NBYTES = NBITS / DATA_BITS;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [TW-1:0]      TMO_LAST  = TW'(BYTE_TIMEOUT - 1);
  // Word count that means "every memory location has been written".
  localparam logic [ADDR_BITS:0] DEPTH     = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t               state_q;
  logic                 rx_prev_q;
  logic [BCW-1:0]       byte_cnt_q;
  logic [NBITS-1:0]     sr_q;
  logic [TW-1:0]        tmo_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS:0]   word_count_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [NBITS-1:0]     mem_data_q;
  logic                 mem_write_q;
  logic                 error_q;

  logic                 accept;
  logic [NBITS-1:0]     sr_d;

  // A byte is taken only on a rising edge of i_rx_ready seen while receiving.
  assign accept = (state_q == S_RECV) && i_rx_ready && !rx_prev_q;

  generate
    if (NBYTES == 1) begin : g_one_byte
      assign sr_d = i_rx_data;
    end else if (MSB_FIRST) begin : g_msb_first
      assign sr_d = {sr_q[NBITS-DATA_BITS-1:0], i_rx_data};
    end else begin : g_lsb_first
      assign sr_d = {i_rx_data, sr_q[NBITS-1:DATA_BITS]};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      rx_prev_q    <= 1'b0;
      byte_cnt_q   <= '0;
      sr_q         <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_write_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      rx_prev_q   <= i_rx_ready;
      mem_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q      <= S_RECV;
            addr_q       <= '0;
            word_count_q <= '0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            sr_q         <= '0;
            error_q      <= 1'b0;
          end
        end
        S_RECV: begin
          // An accept takes priority over a timeout that expires in the same cycle.
          if (accept) begin
            sr_q  <= sr_d;
            tmo_q <= '0;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              state_q    <= S_WRITE;
              // The write decision is made here, so the strobe leaves a register
              // during the WRITE cycle. WRITE repeats the same test to pick the
              // next state.
              if (sr_d != END_WORD && word_count_q != DEPTH) begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_data_q  <= sr_d;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end else if (BYTE_TIMEOUT != 0 && byte_cnt_q != '0) begin
            if (tmo_q == TMO_LAST) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              byte_cnt_q <= '0;
              tmo_q      <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (sr_q == END_WORD) begin
            state_q <= S_DONE;
          end else if (word_count_q == DEPTH) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end else begin
            state_q      <= S_RECV;
            addr_q       <= addr_q + 1'b1;
            word_count_q <= word_count_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_write  = mem_write_q;
  assign o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done       = (state_q == S_DONE);
  assign o_error      = error_q;
  assign o_word_count = word_count_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_debug_word_loader.sv
module tb_debug_word_loader;

  logic clk, rst, start, rx_ready;
  logic [7:0] rx_data;

  // u_m: MSB first, 4-word memory, timeout 50. u_l: LSB first, 256 words, no timeout.
  logic [1:0]  addr_m;  logic [31:0] data_m;  logic wr_m, busy_m, done_m, err_m;
  logic [2:0]  wc_m;    logic [2:0]  state_m;
  logic [7:0]  addr_l;  logic [31:0] data_l;  logic wr_l, busy_l, done_l, err_l;
  logic [8:0]  wc_l;    logic [2:0]  state_l;

  debug_word_loader #(.NBITS(32), .DATA_BITS(8), .ADDR_BITS(2), .MSB_FIRST(1'b1),
                      .END_WORD(32'hFFFF_FFFF), .BYTE_TIMEOUT(50)) u_m (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rx_ready(rx_ready), .i_rx_data(rx_data),
    .o_mem_addr(addr_m), .o_mem_data(data_m), .o_mem_write(wr_m), .o_busy(busy_m),
    .o_done(done_m), .o_error(err_m), .o_word_count(wc_m), .o_state(state_m));

  debug_word_loader #(.NBITS(32), .DATA_BITS(8), .ADDR_BITS(8), .MSB_FIRST(1'b0),
                      .END_WORD(32'hFFFF_FFFF), .BYTE_TIMEOUT(0)) u_l (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rx_ready(rx_ready), .i_rx_data(rx_data),
    .o_mem_addr(addr_l), .o_mem_data(data_l), .o_mem_write(wr_l), .o_busy(busy_l),
    .o_done(done_l), .o_error(err_l), .o_word_count(wc_l), .o_state(state_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture every write strobe and done pulse seen by each instance.
  logic [1:0]  q_addr_m[$];
  logic [31:0] q_data_m[$];
  logic [7:0]  q_addr_l[$];
  logic [31:0] q_data_l[$];
  int done_cnt_m = 0;
  int done_cnt_l = 0;

  always @(negedge clk) begin
    if (wr_m) begin q_addr_m.push_back(addr_m); q_data_m.push_back(data_m); end
    if (wr_l) begin q_addr_l.push_back(addr_l); q_data_l.push_back(data_l); end
    if (done_m) done_cnt_m <= done_cnt_m + 1;
    if (done_l) done_cnt_l <= done_cnt_l + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the level drops.
  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int hold);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], hold);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;     // bytes in send order, first byte in bits 31:24
    int          hold;     // cycles i_rx_ready stays high per byte
    int          strobe;   // expected number of writes
    int          done;     // expected number of done pulses
    logic [31:0] data_m;
    logic [31:0] data_l;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_m, n_l, d_m, d_l, waited;
    vecs[0] = '{word: 32'h0023_0020, hold: 1, strobe: 1, done: 0,
                data_m: 32'h0023_0020, data_l: 32'h2000_2300, addr: 8'd0};
    vecs[1] = '{word: 32'h1122_3344, hold: 3, strobe: 1, done: 0,
                data_m: 32'h1122_3344, data_l: 32'h4433_2211, addr: 8'd1};
    vecs[2] = '{word: 32'hDEAD_BEEF, hold: 2, strobe: 1, done: 0,
                data_m: 32'hDEAD_BEEF, data_l: 32'hEFBE_ADDE, addr: 8'd2};
    vecs[3] = '{word: 32'hFFFF_FFFF, hold: 1, strobe: 0, done: 1,
                data_m: 32'h0, data_l: 32'h0, addr: 8'd0};

    rst = 1'b1; start = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_state_m", state_m, 0); chk("rst_addr_m", addr_m, 0);
    chk("rst_data_m", data_m, 0);   chk("rst_wr_m", wr_m, 0);
    chk("rst_busy_m", busy_m, 0);   chk("rst_done_m", done_m, 0);
    chk("rst_err_m", err_m, 0);     chk("rst_wc_m", wc_m, 0);
    chk("rst_state_l", state_l, 0); chk("rst_data_l", data_l, 0);
    rst = 1'b0;
    @(negedge clk);

    // Level already high before start must not count as a byte.
    rx_data = 8'hAA; rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    chk("armed_busy_m", busy_m, 1); chk("armed_state_l", state_l, 1);
    rx_ready = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      n_m = q_data_m.size(); n_l = q_data_l.size();
      d_m = done_cnt_m;      d_l = done_cnt_l;
      send_word(vecs[v].word, vecs[v].hold);
      repeat (2) @(negedge clk);
      #1;
      $display("word %0d: sent %h hold %0d", v, vecs[v].word, vecs[v].hold);
      chk($sformatf("v%0d_strobes_m", v), q_data_m.size() - n_m, vecs[v].strobe);
      chk($sformatf("v%0d_strobes_l", v), q_data_l.size() - n_l, vecs[v].strobe);
      chk($sformatf("v%0d_done_m", v), done_cnt_m - d_m, vecs[v].done);
      chk($sformatf("v%0d_done_l", v), done_cnt_l - d_l, vecs[v].done);
      if (vecs[v].strobe != 0 && q_data_m.size() > n_m && q_data_l.size() > n_l) begin
        chk($sformatf("v%0d_data_m", v), q_data_m[$], vecs[v].data_m);
        chk($sformatf("v%0d_addr_m", v), q_addr_m[$], vecs[v].addr[1:0]);
        chk($sformatf("v%0d_data_l", v), q_data_l[$], vecs[v].data_l);
        chk($sformatf("v%0d_addr_l", v), q_addr_l[$], vecs[v].addr);
      end
    end
    chk("end_wc_m", wc_m, 3); chk("end_wc_l", wc_l, 3);
    chk("end_state_m", state_m, 0); chk("end_busy_l", busy_l, 0);
    chk("end_held_data_m", data_m, 32'hDEAD_BEEF);

    // Inter-byte timeout on u_m; u_l has the timeout disabled.
    pulse_start();
    n_m = q_data_m.size();
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    $display("timeout: sent 2 bytes, idling");
    repeat (45) @(negedge clk);
    chk("tmo_not_early_m", err_m, 0);
    waited = 0;
    while (!err_m && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("tmo_fired_m", err_m, 1);
    chk("tmo_cycle_m", waited, 4);
    chk("tmo_no_strobe_m", q_data_m.size() - n_m, 0);
    chk("tmo_wc_m", wc_m, 0);
    repeat (2) @(negedge clk);
    chk("tmo_idle_m", state_m, 0); chk("tmo_sticky_m", err_m, 1);
    chk("tmo_off_err_l", err_l, 0); chk("tmo_off_busy_l", busy_l, 1);

    // New start clears the error on u_m; u_l is mid-word so the start is ignored.
    pulse_start();
    #1;
    chk("restart_err_m", err_m, 0); chk("restart_state_m", state_m, 1);
    n_m = q_data_m.size(); n_l = q_data_l.size();
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    repeat (2) @(negedge clk);
    $display("resume: sent 55 66");
    chk("resume_strobes_l", q_data_l.size() - n_l, 1);
    if (q_data_l.size() > n_l) begin
      chk("resume_data_l", q_data_l[$], 32'h6655_2211);
      chk("resume_addr_l", q_addr_l[$], 0);
    end
    chk("resume_strobes_m", q_data_m.size() - n_m, 0);
    chk("resume_busy_m", busy_m, 1);

    // Reset mid-word on u_m, then a clean word.
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state_m", state_m, 0); chk("midrst_data_l", data_l, 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    n_m = q_data_m.size(); n_l = q_data_l.size();
    send_word(32'h1122_3344, 1);
    repeat (2) @(negedge clk);
    $display("post-reset word: sent 11223344");
    chk("prst_strobes_m", q_data_m.size() - n_m, 1);
    if (q_data_m.size() > n_m) begin
      chk("prst_data_m", q_data_m[$], 32'h1122_3344);
      chk("prst_addr_m", q_addr_m[$], 0);
    end
    chk("prst_data_l", data_l, 32'h4433_2211);

    // Overflow: u_m holds 4 words, so the 5th word errors.
    for (int k = 1; k < 4; k++) begin
      n_m = q_data_m.size();
      send_word(32'hA0B0_C0D0 + k, 1);
      repeat (2) @(negedge clk);
      $display("fill word %0d: sent %h", k, 32'hA0B0_C0D0 + k);
      chk($sformatf("fill%0d_strobes_m", k), q_data_m.size() - n_m, 1);
      chk($sformatf("fill%0d_addr_m", k), addr_m, k);
      chk($sformatf("fill%0d_data_m", k), data_m, 32'hA0B0_C0D0 + k);
      chk($sformatf("fill%0d_addr_l", k), addr_l, k);
    end
    n_m = q_data_m.size(); n_l = q_data_l.size();
    send_word(32'h0102_0304, 1);
    repeat (2) @(negedge clk);
    $display("overflow word: sent 01020304");
    chk("ovf_no_strobe_m", q_data_m.size() - n_m, 0);
    chk("ovf_err_m", err_m, 1);
    chk("ovf_wc_m", wc_m, 4);
    chk("ovf_state_m", state_m, 0);
    chk("ovf_strobes_l", q_data_l.size() - n_l, 1);
    chk("ovf_data_l", data_l, 32'h0403_0201);
    chk("ovf_addr_l", addr_l, 4);
    chk("ovf_err_l", err_l, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
